cacheline_burst_adaptor: RTL and testbench

- Responder for the L2 cache's physical-memory port: it accepts 256-bit line read and write requests (pmem_read, pmem_write, pmem_address, pmem_wdata) and returns pmem_rdata and pmem_resp.
- Each line request is serviced as a 4-beat, 64-bit burst on the board memory interface.
- Sits between l2_cache and physical memory, and buffers a full line in each direction.

---
 rtl/cacheline_burst_adaptor_if.sv | 37 +++
 rtl/cacheline_burst_adaptor.sv | 120 ++++++++++++
 tb/tb_cacheline_burst_adaptor.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_burst_adaptor_if.sv
// Bundles the L2-facing line port and the memory-facing burst port.
// The adaptor uses the slave view; whoever drives requests and serves
// bursts (the L2 side plus memory, or a testbench) uses the master view.
interface cacheline_burst_adaptor_if #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
);
    // L2 cache physical-memory port
    logic               pmem_read;
    logic               pmem_write;
    logic [31:0]        pmem_address;
    logic [s_line-1:0]  pmem_wdata;
    logic [s_line-1:0]  pmem_rdata;
    logic               pmem_resp;

    // Board memory burst port
    logic               burst_read;
    logic               burst_write;
    logic [31:0]        burst_address;
    logic [s_burst-1:0] burst_wdata;
    logic [s_burst-1:0] burst_rdata;
    logic               burst_resp;

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp,
        output burst_read, burst_write, burst_address, burst_wdata,
        input  burst_rdata, burst_resp
    );

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp,
        input  burst_read, burst_write, burst_address, burst_wdata,
        output burst_rdata, burst_resp
    );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Turns one 256-bit line read/write from the L2 cache into a 4-beat 64-bit
// burst on board memory. A full line is buffered in each direction: the
// write line is captured at accept time, the read line is assembled beat by
// beat and then held on pmem_rdata until the next read overwrites it.
module cacheline_burst_adaptor #(
    parameter int s_offset = 5,
    parameter int s_line   = 256,
    parameter int s_burst  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    cacheline_burst_adaptor_if.slave  bus
);
    // Beat count is a consequence of the two widths, never set on its own.
    localparam int num_beats = s_line / s_burst;
    localparam int cnt_w     = $clog2(num_beats);
    localparam logic [cnt_w-1:0] last_beat = cnt_w'(num_beats - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [cnt_w-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [s_line-1:0]  wline_q, wline_d;
    logic [s_line-1:0]  rline_q, rline_d;

    logic [num_beats-1:0] rbeat_en;
    logic [s_burst-1:0]   wbeat [num_beats];

    // Per-beat views of the line buffers: write line split into beats for
    // the outgoing mux, read line updated one slice at a time.
    for (genvar gi = 0; gi < num_beats; gi++) begin : g_beat
        assign wbeat[gi] = wline_q[gi*s_burst +: s_burst];
        assign rline_d[gi*s_burst +: s_burst] =
            rbeat_en[gi] ? bus.burst_rdata : rline_q[gi*s_burst +: s_burst];
    end

    assign bus.pmem_rdata    = rline_q;
    assign bus.burst_address = addr_q;
    assign bus.burst_wdata   = wbeat[cnt_q];

    // State, beat counter and line buffers; reset aborts any burst silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end

    // Next-state logic and Moore outputs; upstream inputs are only sampled
    // in IDLE so changes while busy have no effect.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        addr_d          = addr_q;
        wline_d         = wline_q;
        rbeat_en        = '0;
        bus.burst_read  = 1'b0;
        bus.burst_write = 1'b0;
        bus.pmem_resp   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Write takes priority if upstream illegally raises both.
                if (bus.pmem_write) begin
                    addr_d  = {bus.pmem_address[31:s_offset], s_offset'(0)};
                    wline_d = bus.pmem_wdata;
                    cnt_d   = '0;
                    state_d = WRITE;
                end else if (bus.pmem_read) begin
                    addr_d  = {bus.pmem_address[31:s_offset], s_offset'(0)};
                    cnt_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                bus.burst_read = 1'b1;
                if (bus.burst_resp) begin
                    rbeat_en = num_beats'(1) << cnt_q;
                    if (cnt_q == last_beat) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                bus.burst_write = 1'b1;
                if (bus.burst_resp) begin
                    if (cnt_q == last_beat) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                bus.pmem_resp = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Randomized self-checking bench for cacheline_burst_adaptor. The bench acts
// as both the L2 requester and a memory with random wait states; expected
// values come from a line-level model (aligned address, line slices, last
// completed read line).
module tb_cacheline_burst_adaptor;
    logic clk;
    logic rst;

    cacheline_burst_adaptor_if bus ();

    cacheline_burst_adaptor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;
    int txn_id        = 0;

    // Model state: the line pmem_rdata should currently show.
    logic [255:0] model_rdata;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks_total++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            checks_passed++;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Drive one line transaction from the current negedge until pmem_resp,
    // acting as memory with gaps of min_gap..max_gap cycles between beats.
    task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [255:0] wline, input logic [255:0] rline,
                           input int min_gap, input int max_gap, input bit mutate);
        int k;
        int gap;
        int ncyc;
        bit got_resp;
        logic [31:0]  exp_addr;
        logic [255:0] exp_rdata;
        k = 0; gap = 0; ncyc = 0; got_resp = 1'b0;
        exp_addr  = addr & 32'hFFFF_FFE0;
        exp_rdata = wr ? model_rdata : rline;
        txn_id++;
        $display("txn %0d: %s addr=%h gaps=%0d..%0d mutate=%0d", txn_id,
                 wr ? (rd ? "write(+read)" : "write") : "read", addr, min_gap, max_gap, mutate);

        bus.pmem_write   = wr;
        bus.pmem_read    = rd;
        bus.pmem_address = addr;
        bus.pmem_wdata   = wline;
        bus.burst_resp   = 1'b0;

        while (!got_resp && ncyc < 200) begin
            @(negedge clk);
            ncyc++;
            if (mutate && ncyc == 3) begin
                bus.pmem_address = $urandom;
                bus.pmem_wdata   = rand_line();
            end
            if (bus.pmem_resp) begin
                got_resp = 1'b1;
                check("beats_before_resp", 256'(k), 256'(4));
                check("done_no_burst", {bus.burst_read, bus.burst_write}, 2'b00);
                check("pmem_rdata", bus.pmem_rdata, exp_rdata);
                if (max_gap == 0) check("latency", 256'(ncyc), 256'(5));
                bus.pmem_read  = 1'b0;
                bus.pmem_write = 1'b0;
                bus.burst_resp = 1'b0;
            end else begin
                check("burst_dir", {bus.burst_read, bus.burst_write}, wr ? 2'b01 : 2'b10);
                check("burst_address", bus.burst_address, exp_addr);
                check("beat_in_range", 256'(k < 4), 256'(1));
                if (wr && k < 4) check("burst_wdata", bus.burst_wdata, wline[k*64 +: 64]);
                if (gap == 0 && k < 4) begin
                    bus.burst_resp  = 1'b1;
                    bus.burst_rdata = rline[k*64 +: 64];
                    k++;
                    gap = $urandom_range(max_gap, min_gap);
                end else begin
                    bus.burst_resp  = 1'b0;
                    bus.burst_rdata = {$urandom, $urandom};
                    if (gap > 0) gap--;
                end
            end
        end
        check("resp_seen", 256'(got_resp), 256'(1));
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        bus.burst_resp = 1'b0;
        if (!wr) model_rdata = rline;

        // One cycle later the adaptor must be back in IDLE with no pulse.
        @(negedge clk);
        check("resp_single_pulse", bus.pmem_resp, 1'b0);
        check("idle_no_burst", {bus.burst_read, bus.burst_write}, 2'b00);
        check("rdata_hold", bus.pmem_rdata, model_rdata);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] la;
        logic [255:0] lb;
        logic [255:0] beats;

        rst              = 1'b1;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        bus.burst_rdata  = '0;
        bus.burst_resp   = 1'b0;
        model_rdata      = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", {bus.burst_read, bus.burst_write, bus.pmem_resp}, 3'b000);
        check("reset_rdata", bus.pmem_rdata, model_rdata);
        check("reset_address", bus.burst_address, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Stray burst_resp in IDLE must be ignored
        bus.burst_resp  = 1'b1;
        bus.burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        bus.burst_resp = 1'b0;
        check("idle_ignores_resp", {bus.burst_read, bus.burst_write, bus.pmem_resp}, 3'b000);
        check("idle_rdata_kept", bus.pmem_rdata, model_rdata);

        // Read, zero wait, unaligned address
        beats = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        run_txn(1'b0, 1'b1, 32'h0000_1234, '0, beats, 0, 0, 1'b0);

        // Write with exactly 2 idle cycles between beats
        la = rand_line();
        run_txn(1'b1, 1'b0, 32'h0000_5678, la, rand_line(), 2, 2, 1'b0);

        // Read and write together: write wins, pmem_rdata untouched
        run_txn(1'b1, 1'b1, 32'h0000_9ABC, rand_line(), rand_line(), 0, 1, 1'b0);

        // Reset in the middle of a read after two beats
        lb = rand_line();
        txn_id++;
        $display("txn %0d: read aborted by reset after 2 beats", txn_id);
        bus.pmem_read    = 1'b1;
        bus.pmem_address = 32'h0000_4040;
        @(negedge clk);
        check("abort_burst_read", bus.burst_read, 1'b1);
        bus.burst_resp  = 1'b1;
        bus.burst_rdata = lb[63:0];
        @(negedge clk);
        bus.burst_rdata = lb[127:64];
        @(negedge clk);
        bus.burst_resp = 1'b0;
        check("abort_slice0", bus.pmem_rdata[63:0], lb[63:0]);
        #2 rst = 1'b1;
        #1;
        model_rdata = '0;
        check("abort_burst_read_drop", bus.burst_read, 1'b0);
        check("abort_rdata_clear", bus.pmem_rdata, model_rdata);
        check("abort_no_resp", bus.pmem_resp, 1'b0);
        bus.pmem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("after_abort_quiet", {bus.burst_read, bus.burst_write, bus.pmem_resp}, 3'b000);
        end
        run_txn(1'b0, 1'b1, 32'h0000_4040, '0, rand_line(), 0, 2, 1'b0);

        // Back-to-back: write 0x100 then read 0x200 straight after pmem_resp
        run_txn(1'b1, 1'b0, 32'h0000_0100, rand_line(), rand_line(), 0, 0, 1'b0);
        run_txn(1'b0, 1'b1, 32'h0000_0200, '0, rand_line(), 0, 0, 1'b0);

        // Upstream address and data change mid-write
        run_txn(1'b1, 1'b0, 32'h0000_7700, rand_line(), rand_line(), 1, 2, 1'b1);

        // Random mix of reads and writes
        for (int t = 0; t < 16; t++) begin
            bit is_wr;
            int g;
            is_wr = $urandom_range(1, 0);
            g     = $urandom_range(3, 0);
            run_txn(is_wr, ~is_wr, $urandom, rand_line(), rand_line(), 0, g,
                    1'($urandom_range(1, 0)));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
